// File: rtl/i2s_wb_tx_fifo.sv
`timescale 1ns/1ps
// I2S transmitter fed by a Wishbone-programmable sample FIFO. The external bit
// clock and word select are sampled in i2s_clk_i and only their edges are used.
module i2s_wb_tx_fifo #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_AW      = 4
) (
  input  logic        i2s_clk_i,
  input  logic        i2s_rst_ni,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  input  logic [31:0] wbs_addr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  input  logic        i2s_sck_i,
  input  logic        i2s_ws_i,
  output logic        i2s_sd_o,
  output logic        irq_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(SAMPLE_WIDTH);
  localparam int MSB   = SAMPLE_WIDTH - 1;

  localparam logic [17:0] A_CTRL   = 18'd0;
  localparam logic [17:0] A_STATUS = 18'd1;
  localparam logic [17:0] A_THRESH = 18'd2;
  localparam logic [17:0] A_DATA   = 18'd3;
  localparam logic [17:0] A_UCNT   = 18'd4;
  localparam logic [31:0] BAD_ADDR = 32'h1BAD_C0DE;

  typedef enum logic [1:0] {SER_IDLE, SER_ARMED, SER_SHIFT} ser_state_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] async_in;
  logic [1:0] meta_reg, sync_reg, hist_reg;
  logic       sck_fall, ws_edge, ws_now;

  assign async_in = {i2s_ws_i, i2s_sck_i};

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
    if (!i2s_rst_ni) begin
      meta_reg <= '0;
      sync_reg <= '0;
      hist_reg <= '0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign sck_fall = hist_reg[0] & ~sync_reg[0];
  assign ws_edge  = sync_reg[1] ^ hist_reg[1];
  assign ws_now   = sync_reg[1];

  // ---------------------------------------------------------------- registers
  logic              enable_reg, lj_reg, mono_reg, irq_en_reg, flush_reg;
  logic              underrun_reg, overflow_reg;
  logic [FIFO_AW:0]  thresh_reg;
  logic [15:0]       ucnt_reg;

  // ---------------------------------------------------------------- bus decode
  logic        req, wr;
  logic [17:0] word_addr;
  logic        wr_ctrl, wr_status, wr_thresh, wr_data, wr_ucnt;
  logic        push, pop, data_err;
  logic [31:0] rdata, status_word;
  logic        unused_bits;

  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign wr        = req & wbs_we_i;
  assign word_addr = wbs_addr_i[19:2];
  assign wr_ctrl   = wr & (word_addr == A_CTRL);
  assign wr_status = wr & (word_addr == A_STATUS);
  assign wr_thresh = wr & (word_addr == A_THRESH);
  assign wr_data   = wr & (word_addr == A_DATA);
  assign wr_ucnt   = wr & (word_addr == A_UCNT);
  assign wbs_rty_o = 1'b0;

  assign unused_bits = ^{wbs_sel_i, wbs_addr_i[31:20], wbs_addr_i[1:0], wbs_data_i};

  // ---------------------------------------------------------------- FIFO
  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0]        wr_ptr_reg, rd_ptr_reg, level;
  logic                    empty, full;

  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (level == '0);
  assign full     = level[FIFO_AW];
  assign push     = wr_data & ~full;
  assign data_err = wr_data & full;

  always_ff @(posedge i2s_clk_i) begin
    if (push)
      mem[wr_ptr_reg[FIFO_AW-1:0]] <= wbs_data_i[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
    if (!i2s_rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush_reg) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------- channel start
  logic                    aligned_reg;
  logic                    start_left, start_right, start, pop_req, underrun_evt;
  logic [SAMPLE_WIDTH-1:0] mono_sample_reg, fifo_head, sample;

  // Right-channel starts are ignored until a left start has been seen since enable.
  assign start_left   = enable_reg & ws_edge & ~ws_now;
  assign start_right  = enable_reg & ws_edge & ws_now & aligned_reg;
  assign start        = start_left | start_right;
  assign pop_req      = start_left | (start_right & ~mono_reg);
  assign pop          = pop_req & ~empty;
  assign underrun_evt = pop_req & empty;
  assign fifo_head    = empty ? '0 : mem[rd_ptr_reg[FIFO_AW-1:0]];
  assign sample       = (start_right & mono_reg) ? mono_sample_reg : fifo_head;

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
    if (!i2s_rst_ni) begin
      aligned_reg     <= 1'b0;
      mono_sample_reg <= '0;
    end else begin
      if (!enable_reg)
        aligned_reg <= 1'b0;
      else if (start_left)
        aligned_reg <= 1'b1;
      if (start_left)
        mono_sample_reg <= fifo_head;
    end
  end

  // ---------------------------------------------------------------- serializer
  ser_state_t              state_reg, state_next;
  logic [SAMPLE_WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    sd_reg, sd_next;

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
    if (!i2s_rst_ni) begin
      state_reg <= SER_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      sd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      sd_reg    <= sd_next;
    end
  end

  // A channel start wins over a coincident sck_fall, so the I2S MSB lands on the next fall.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    sd_next    = sd_reg;
    if (!enable_reg) begin
      state_next = SER_IDLE;
      cnt_next   = '0;
      sd_next    = 1'b0;
    end else if (start) begin
      if (lj_reg) begin
        sd_next    = sample[MSB];
        shift_next = sample << 1;
        cnt_next   = CW'(SAMPLE_WIDTH - 1);
        state_next = SER_SHIFT;
      end else begin
        sd_next    = 1'b0;
        shift_next = sample;
        state_next = SER_ARMED;
      end
    end else if (sck_fall) begin
      case (state_reg)
        SER_ARMED: begin
          sd_next    = shift_reg[MSB];
          shift_next = shift_reg << 1;
          cnt_next   = CW'(SAMPLE_WIDTH - 1);
          state_next = SER_SHIFT;
        end
        SER_SHIFT: begin
          if (cnt_reg == '0) begin
            sd_next    = 1'b0;
            state_next = SER_IDLE;
          end else begin
            sd_next    = shift_reg[MSB];
            shift_next = shift_reg << 1;
            cnt_next   = cnt_reg - CW'(1);
          end
        end
        default: sd_next = 1'b0;
      endcase
    end
  end

  // Gating with enable drops the line in the very cycle enable is cleared.
  assign i2s_sd_o = sd_reg & enable_reg;
  assign irq_o    = irq_en_reg & ((level <= thresh_reg) | underrun_reg);

  // ---------------------------------------------------------------- register file
  always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
    if (!i2s_rst_ni) begin
      enable_reg   <= 1'b0;
      lj_reg       <= 1'b0;
      mono_reg     <= 1'b0;
      irq_en_reg   <= 1'b0;
      flush_reg    <= 1'b0;
      thresh_reg   <= '0;
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
      ucnt_reg     <= '0;
    end else begin
      flush_reg <= wr_ctrl & wbs_data_i[4];
      if (wr_ctrl) begin
        enable_reg <= wbs_data_i[0];
        lj_reg     <= wbs_data_i[1];
        mono_reg   <= wbs_data_i[2];
        irq_en_reg <= wbs_data_i[3];
      end
      if (wr_thresh)
        thresh_reg <= wbs_data_i[FIFO_AW:0];
      underrun_reg <= underrun_evt | (underrun_reg & ~(wr_status & wbs_data_i[2]));
      overflow_reg <= data_err | (overflow_reg & ~(wr_status & wbs_data_i[3]));
      if (wr_ucnt)
        ucnt_reg <= '0;
      else if (underrun_evt && ucnt_reg != 16'hFFFF)
        ucnt_reg <= ucnt_reg + 16'd1;
    end
  end

  always_comb begin
    status_word                 = '0;
    status_word[0]              = empty;
    status_word[1]              = full;
    status_word[2]              = underrun_reg;
    status_word[3]              = overflow_reg;
    status_word[FIFO_AW+16:16]  = level;
  end

  always_comb begin
    rdata = BAD_ADDR;
    case (word_addr)
      A_CTRL: begin
        rdata      = '0;
        rdata[3:0] = {irq_en_reg, mono_reg, lj_reg, enable_reg};
      end
      A_STATUS: rdata = status_word;
      A_THRESH: begin
        rdata            = '0;
        rdata[FIFO_AW:0] = thresh_reg;
      end
      A_DATA:   rdata = '0;
      A_UCNT:   rdata = {16'd0, ucnt_reg};
      default:  rdata = BAD_ADDR;
    endcase
  end

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
    if (!i2s_rst_ni) begin
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbs_data_o <= '0;
    end else begin
      wbs_ack_o <= req & ~data_err;
      wbs_err_o <= data_err;
      if (req)
        wbs_data_o <= wbs_we_i ? 32'd0 : rdata;
    end
  end

endmodule

// File: tb/tb_i2s_wb_tx_fifo.sv
`timescale 1ns/1ps
// Bench for i2s_wb_tx_fifo: register access over Wishbone and capture of each
// 32-bit channel slot on sd, compared against a queue of expected slots.
module tb_i2s_wb_tx_fifo;

  localparam logic [31:0] R_CTRL   = 32'h00;
  localparam logic [31:0] R_STATUS = 32'h04;
  localparam logic [31:0] R_THRESH = 32'h08;
  localparam logic [31:0] R_DATA   = 32'h0C;
  localparam logic [31:0] R_UCNT   = 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_wdata = '0;
  logic [31:0] wb_addr = '0;
  logic [31:0] wb_rdata;
  logic [3:0]  wb_sel = 4'hF;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic        wb_ack, wb_err, wb_rty;
  logic        sck = 1'b1, ws = 1'b1;
  logic        sd, irq;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  i2s_wb_tx_fifo #(.SAMPLE_WIDTH(24), .FIFO_AW(4)) dut (
    .i2s_clk_i (clk),
    .i2s_rst_ni(rst_n),
    .wbs_data_i(wb_wdata),
    .wbs_data_o(wb_rdata),
    .wbs_addr_i(wb_addr),
    .wbs_sel_i (wb_sel),
    .wbs_we_i  (wb_we),
    .wbs_cyc_i (wb_cyc),
    .wbs_stb_i (wb_stb),
    .wbs_ack_o (wb_ack),
    .wbs_err_o (wb_err),
    .wbs_rty_o (wb_rty),
    .i2s_sck_i (sck),
    .i2s_ws_i  (ws),
    .i2s_sd_o  (sd),
    .irq_o     (irq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i2s_slot(input logic [23:0] s);
    return {1'b0, s, 7'd0};
  endfunction

  function automatic logic [31:0] lj_slot(input logic [23:0] s);
    return {s, 8'd0};
  endfunction

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
    @(posedge clk); #1;
    wb_addr = addr; wb_wdata = data; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    $display("[TB] WR 0x%02h <= 0x%08h ack=%0b err=%0b", addr[7:0], data, wb_ack, wb_err);
    check_val("wr_resp", {30'd0, wb_ack, wb_err}, {30'd0, ~exp_err, exp_err});
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    wb_addr = addr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    data = wb_rdata;
    $display("[TB] RD 0x%02h => 0x%08h ack=%0b err=%0b", addr[7:0], data, wb_ack, wb_err);
    check_val("rd_resp", {30'd0, wb_ack, wb_err}, 32'd2);
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    wb_read(addr, v);
    check_val(tag, v, exp);
  endtask

  // ws changes with the falling sck; sd is sampled just before each rising sck.
  task automatic run_channel(input logic ws_val, input int nbits, output logic [31:0] slot);
    slot = '0;
    for (int b = 0; b < nbits; b++) begin
      sck = 1'b0;
      if (b == 0) ws = ws_val;
      #80;
      slot = {slot[30:0], sd};
      sck = 1'b1;
      #80;
    end
  endtask

  task automatic run_frames(input int n);
    logic [31:0] slot, exp;
    @(posedge clk); #5;
    for (int f = 0; f < n; f++) begin
      for (int ch = 0; ch < 2; ch++) begin
        run_channel(ch == 1, 32, slot);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        $display("[TB] SLOT f%0d %s sd=0x%08h exp=0x%08h", f, (ch == 1) ? "R" : "L", slot, exp);
        check_val((ch == 1) ? "slot_right" : "slot_left", slot, exp);
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] slot;
    int          waited;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sd", {31'd0, sd}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_ackerr", {30'd0, wb_ack, wb_err}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);

    read_check("rst_ctrl", R_CTRL, 32'h0);
    read_check("rst_status", R_STATUS, 32'h1);
    read_check("rst_thresh", R_THRESH, 32'h0);
    read_check("rst_ucnt", R_UCNT, 32'h0);
    read_check("rst_data", R_DATA, 32'h0);
    read_check("bad_addr", 32'h20, 32'h1BAD_C0DE);

    // stereo I2S
    wb_write(R_DATA, 32'h00AB_CDEF, 1'b0);
    wb_write(R_DATA, 32'h0012_3456, 1'b0);
    exp_q.push_back(i2s_slot(24'hABCDEF));
    exp_q.push_back(i2s_slot(24'h123456));
    wb_write(R_CTRL, 32'h1, 1'b0);
    run_frames(1);
    read_check("stereo_status", R_STATUS, 32'h1);
    read_check("stereo_ucnt", R_UCNT, 32'h0);
    wb_write(R_CTRL, 32'h0, 1'b0);

    // underrun on an empty FIFO
    wb_write(R_CTRL, 32'h9, 1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h0);
    run_frames(3);
    read_check("urun_cnt", R_UCNT, 32'd6);
    read_check("urun_status", R_STATUS, 32'h5);
    check_val("urun_irq", {31'd0, irq}, 32'd1);
    wb_write(R_STATUS, 32'h4, 1'b0);
    read_check("urun_clear", R_STATUS, 32'h1);
    wb_write(R_UCNT, 32'h1234, 1'b0);
    read_check("ucnt_clear", R_UCNT, 32'h0);
    wb_write(R_CTRL, 32'h0, 1'b0);

    // overflow on the 17th push, then flush timing seen through irq
    for (int i = 0; i < 16; i++) wb_write(R_DATA, 32'h0010_0000 + i, 1'b0);
    wb_write(R_DATA, 32'h00FF_FFFF, 1'b1);
    read_check("ovf_status", R_STATUS, 32'h0010_000A);
    wb_write(R_CTRL, 32'h8, 1'b0);
    check_val("irq_full", {31'd0, irq}, 32'd0);
    wb_write(R_CTRL, 32'h18, 1'b0);
    check_val("irq_flush_resp", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check_val("irq_flush_next", {31'd0, irq}, 32'd1);
    read_check("flush_ctrl", R_CTRL, 32'h8);
    read_check("flush_status", R_STATUS, 32'h9);
    wb_write(R_STATUS, 32'h8, 1'b0);
    read_check("ovf_clear", R_STATUS, 32'h1);
    wb_write(R_CTRL, 32'h0, 1'b0);

    // mono + left-justified: one pop per frame, both channels identical
    wb_write(R_DATA, 32'h0080_0001, 1'b0);
    wb_write(R_DATA, 32'h005A_5A5A, 1'b0);
    exp_q.push_back(lj_slot(24'h800001));
    exp_q.push_back(lj_slot(24'h800001));
    wb_write(R_CTRL, 32'h7, 1'b0);
    run_frames(1);
    read_check("mono_level1", R_STATUS, 32'h0001_0000);
    exp_q.push_back(lj_slot(24'h5A5A5A));
    exp_q.push_back(lj_slot(24'h5A5A5A));
    run_frames(1);
    read_check("mono_level0", R_STATUS, 32'h1);
    read_check("mono_ucnt", R_UCNT, 32'h0);
    wb_write(R_CTRL, 32'h0, 1'b0);

    // watermark interrupt
    wb_write(R_THRESH, 32'h2, 1'b0);
    wb_write(R_DATA, 32'h0011_1111, 1'b0);
    wb_write(R_DATA, 32'h0022_2222, 1'b0);
    wb_write(R_DATA, 32'h0033_3333, 1'b0);
    wb_write(R_CTRL, 32'h9, 1'b0);
    check_val("irq_above_wm", {31'd0, irq}, 32'd0);
    exp_q.push_back(i2s_slot(24'h111111));
    exp_q.push_back(i2s_slot(24'h222222));
    waited = 0;
    fork
      run_frames(1);
      begin
        while (irq !== 1'b1 && waited < 3000) begin
          @(posedge clk);
          waited++;
        end
        check_val("irq_rise", {31'd0, irq}, 32'd1);
        wb_read(R_STATUS, rd);
        check_val("lvl_at_irq", rd, 32'h0002_0000);
      end
    join
    read_check("wm_level1", R_STATUS, 32'h0001_0000);
    check_val("sb_drain", exp_q.size(), 32'd0);

    // asynchronous reset in the middle of a word (0x333333: bits 0,0,1,...)
    @(posedge clk); #5;
    run_channel(1'b0, 4, slot);
    check_val("partial_bits", slot, 32'h1);
    check_val("sd_before_rst", {31'd0, sd}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("sd_async_rst", {31'd0, sd}, 32'd0);
    check_val("irq_async_rst", {31'd0, irq}, 32'd0);
    #20;
    ws = 1'b1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    read_check("post_rst_status", R_STATUS, 32'h1);
    read_check("post_rst_ctrl", R_CTRL, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
